// File: rtl/alarm_ctrl.sv
// Alarm-side controller: alarm time registers plus the ring / snooze / dismiss FSM
// that drives the buzzer from the time/alarm comparator's level match.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       sec_tick,
    input  logic       match,
    input  logic       alarm_on,
    input  logic       set_mode,
    input  logic       min_inc,
    input  logic       hrs_inc,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [6:0] amin,
    output logic [6:0] ahrs,
    output logic       ring,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);
    localparam logic [1:0]    MAX_CNT   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rtmr_q, rtmr_d;
    logic [SW-1:0] stmr_q, stmr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [6:0]    amin_q, amin_d;
    logic [6:0]    ahrs_q, ahrs_d;
    logic          match_d_q;
    logic          ring_q, ring_d;
    logic          snz_q, snz_d;
    logic          trig;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            rtmr_q    <= '0;
            stmr_q    <= '0;
            cnt_q     <= '0;
            amin_q    <= '0;
            ahrs_q    <= '0;
            match_d_q <= 1'b1;
            ring_q    <= 1'b0;
            snz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rtmr_q    <= rtmr_d;
            stmr_q    <= stmr_d;
            cnt_q     <= cnt_d;
            amin_q    <= amin_d;
            ahrs_q    <= ahrs_d;
            match_d_q <= match;
            ring_q    <= ring_d;
            snz_q     <= snz_d;
        end
    end

    always_comb begin
        amin_d = amin_q;
        ahrs_d = ahrs_q;
        if (set_mode) begin
            if (min_inc) amin_d = (amin_q == 7'd59) ? '0 : amin_q + 7'd1;
            if (hrs_inc) ahrs_d = (ahrs_q == 7'd23) ? '0 : ahrs_q + 7'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        rtmr_d  = rtmr_q;
        stmr_d  = stmr_q;
        cnt_d   = cnt_q;
        trig    = match & ~match_d_q & alarm_on & ~set_mode;

        // Disarm or edit forces IDLE but keeps the snooze count for that cycle.
        if (!alarm_on || set_mode) begin
            state_d = IDLE;
            rtmr_d  = '0;
            stmr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rtmr_d = '0;
                    cnt_d  = '0;
                    if (trig) state_d = RINGING;
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d = DONE;
                    end else if (snooze && (cnt_q < MAX_CNT)) begin
                        state_d = SNOOZE;
                        stmr_d  = SNZ_LOAD;
                        cnt_d   = cnt_q + 2'd1;
                    end else if (sec_tick) begin
                        if (rtmr_q == RING_LAST) state_d = DONE;
                        else                     rtmr_d  = rtmr_q + RW'(1);
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_d = DONE;
                    end else if (sec_tick) begin
                        if (stmr_q == SW'(1)) begin
                            state_d = RINGING;
                            rtmr_d  = '0;
                        end else begin
                            stmr_d = stmr_q - SW'(1);
                        end
                    end
                end
                DONE: begin
                    rtmr_d = '0;
                    stmr_d = '0;
                    if (!match) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        ring_d = (state_d == RINGING);
        snz_d  = (state_d == SNOOZE);
    end

    assign amin       = amin_q;
    assign ahrs       = ahrs_q;
    assign ring       = ring_q;
    assign snoozing   = snz_q;
    assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for ring timeout, repeated snooze and async reset.
module tb_alarm_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       sec_tick, match, alarm_on, set_mode;
    logic       min_inc, hrs_inc, snooze, dismiss;
    logic [6:0] amin, ahrs;
    logic       ring, snoozing;
    logic [1:0] snooze_cnt;

    int checks   = 0;
    int failures = 0;

    alarm_ctrl #(.RING_SECS(60), .SNOOZE_SECS(540), .MAX_SNOOZE(3)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .sec_tick   (sec_tick),
        .match      (match),
        .alarm_on   (alarm_on),
        .set_mode   (set_mode),
        .min_inc    (min_inc),
        .hrs_inc    (hrs_inc),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .amin       (amin),
        .ahrs       (ahrs),
        .ring       (ring),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       sm, mi, hi, ao, m, sn, di, tk;
        logic       e_ring, e_snz;
        logic [1:0] e_cnt;
        logic [6:0] e_amin, e_ahrs;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_pulses();
        sec_tick = 0; min_inc = 0; hrs_inc = 0; snooze = 0; dismiss = 0;
    endtask

    initial begin
        //               sm mi hi ao m  sn di tk  ring snz cnt amin ahrs
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,7'd2,7'd2};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,2'd1,7'd2,7'd2};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,2'd1,7'd2,7'd2};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,2'd1,7'd2,7'd2};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,2'd1,7'd2,7'd2};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd1,7'd2,7'd2};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,7'd2,7'd2};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,7'd2,7'd2};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,7'd2,7'd2};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,2'd1,7'd2,7'd2};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd1,7'd2,7'd2};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};
        vecs[23] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,7'd2,7'd2};

        Reset = 1; match = 0; alarm_on = 0; set_mode = 0;
        clear_pulses();
        step(); step();
        Reset = 0;
        step();
        chk("rst_ring", ring, 0);
        chk("rst_snoozing", snoozing, 0);
        chk("rst_cnt", snooze_cnt, 0);
        chk("rst_amin", amin, 0);
        chk("rst_ahrs", ahrs, 0);

        // Alarm time setting with wrap
        set_mode = 1;
        min_inc  = 1;
        for (int i = 0; i < 60; i++) step();
        chk("amin_wrap0", amin, 0);
        step();
        chk("amin_61", amin, 1);
        min_inc = 0; hrs_inc = 1;
        for (int i = 0; i < 25; i++) step();
        chk("ahrs_25", ahrs, 1);
        chk("amin_kept", amin, 1);
        hrs_inc = 0; set_mode = 0;
        step();

        for (int i = 0; i < NV; i++) begin
            set_mode = vecs[i].sm; min_inc = vecs[i].mi; hrs_inc = vecs[i].hi;
            alarm_on = vecs[i].ao; match = vecs[i].m;   snooze  = vecs[i].sn;
            dismiss  = vecs[i].di; sec_tick = vecs[i].tk;
            step();
            chk($sformatf("v%0d_ring", i), ring, vecs[i].e_ring);
            chk($sformatf("v%0d_snz", i), snoozing, vecs[i].e_snz);
            chk($sformatf("v%0d_cnt", i), snooze_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_amin", i), amin, vecs[i].e_amin);
            chk($sformatf("v%0d_ahrs", i), ahrs, vecs[i].e_ahrs);
        end
        clear_pulses(); set_mode = 0; alarm_on = 1; match = 0;
        step();

        // Ring timeout after exactly 60 ticks
        match = 1;
        step();
        chk("to_ring_start", ring, 1);
        sec_tick = 1;
        for (int i = 0; i < 59; i++) step();
        chk("to_ring_59", ring, 1);
        step();
        chk("to_ring_60", ring, 0);
        for (int i = 0; i < 10; i++) step();
        chk("to_no_retrig", ring, 0);
        chk("to_no_snz", snoozing, 0);
        sec_tick = 0; match = 0;
        step();
        match = 1;
        step();
        chk("to_rering", ring, 1);

        // Three full snoozes, then a saturated one
        for (int k = 1; k <= 3; k++) begin
            snooze = 1;
            step();
            snooze = 0;
            chk($sformatf("snz%0d_snoozing", k), snoozing, 1);
            chk($sformatf("snz%0d_ring", k), ring, 0);
            chk($sformatf("snz%0d_cnt", k), snooze_cnt, k);
            sec_tick = 1;
            for (int i = 0; i < 539; i++) step();
            chk($sformatf("snz%0d_539", k), ring, 0);
            step();
            chk($sformatf("snz%0d_540", k), ring, 1);
            chk($sformatf("snz%0d_back", k), snoozing, 0);
            sec_tick = 0;
        end
        snooze = 1;
        step();
        snooze = 0;
        chk("snz4_ring", ring, 1);
        chk("snz4_snoozing", snoozing, 0);
        chk("snz4_cnt", snooze_cnt, 3);
        dismiss = 1;
        step();
        dismiss = 0;
        chk("dis_ring", ring, 0);
        chk("dis_cnt", snooze_cnt, 3);
        match = 0;
        step();
        match = 1;
        step();
        chk("pre_rst_ring", ring, 1);

        // Async reset between edges, release with match still high
        #2 Reset = 1;
        #1 chk("async_rst_ring", ring, 0);
        #2 Reset = 0;
        step(); step(); step();
        chk("post_rst_ring", ring, 0);
        chk("post_rst_cnt", snooze_cnt, 0);
        chk("post_rst_amin", amin, 0);
        match = 0;
        step();
        match = 1;
        step();
        chk("post_rst_rering", ring, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm-side controller for the lab 2 clock. It owns the alarm-time registers `amin`/`ahrs` that feed the time/alarm match comparator. It consumes that comparator's level match output as `match`. It runs the ring / snooze / dismiss state machine that drives the buzzer.

## Interface
- `RING_SECS`, default 60: seconds the alarm rings before it auto-stops.
- `SNOOZE_SECS`, default 540: seconds in one snooze interval.
- `MAX_SNOOZE`, default 3: number of snoozes allowed per alarm event.
- `Clk`, input, 1: single system clock. All state updates on its rising edge.
- `Reset`, input, 1: asynchronous, active-high. It clears all state immediately on assertion.
- `sec_tick`, input, 1: one-cycle pulse, once per second.
- `match`, input, 1: level from the comparator. It is 1 while time equals alarm time and the comparator is enabled.
- `alarm_on`, input, 1: user arm switch. A level signal.
- `set_mode`, input, 1: while 1, alarm time is editable and ringing is suppressed.
- `min_inc`, input, 1: one-cycle pulse. Increments `amin` in set mode.
- `hrs_inc`, input, 1: one-cycle pulse. Increments `ahrs` in set mode.
- `snooze`, input, 1: one-cycle pulse from the snooze button.
- `dismiss`, input, 1: one-cycle pulse from the off button.
- `amin`, output, 7: alarm minutes, 0–59.
- `ahrs`, output, 7: alarm hours, 0–23.
- `ring`, output, 1: buzzer drive. It is 1 exactly while in RINGING.
- `snoozing`, output, 1: 1 exactly while in SNOOZE.
- `snooze_cnt`, output, 2: snoozes used in the current event. Saturates at `MAX_SNOOZE`.

## Operation
- Reset values:
  - state = IDLE.
  - `amin`=0, `ahrs`=0.
  - `ring`=0, `snoozing`=0, `snooze_cnt`=0.
  - Ring and snooze timers = 0.
  - `match_d`=1, so a match already present at reset does not trigger.
- Alarm time editing:
  - Active only when `set_mode`=1.
  - `min_inc` steps `amin` by 1, wrapping 59→0.
  - `hrs_inc` steps `ahrs` by 1, wrapping 23→0.
  - Simultaneous `min_inc` and `hrs_inc` both apply. Minute wrap does not carry into hours.
  - Increments are ignored when `set_mode`=0.
- Trigger: `trig = match & ~match_d & alarm_on & ~set_mode`, where `match_d` is `match` registered every cycle.
- States:
  - IDLE:
    - `trig` → RINGING.
    - Ring timer = 0, `snooze_cnt` = 0.
  - RINGING:
    - `dismiss` → DONE.
    - Else `snooze` with `snooze_cnt` < `MAX_SNOOZE` → SNOOZE. Snooze timer = `SNOOZE_SECS`, `snooze_cnt`+1.
    - `snooze` with `snooze_cnt` = `MAX_SNOOZE` is ignored and ringing continues.
    - Else on `sec_tick`, ring timer +1. When the timer equals `RING_SECS`-1 on a tick → DONE.
  - SNOOZE:
    - `dismiss` → DONE.
    - `sec_tick` decrements the snooze timer. A tick while the timer = 1 → RINGING with ring timer = 0.
    - `snooze` is ignored.
  - DONE:
    - Waits for `match`=0, then → IDLE.
    - This blocks retriggering within the same alarm minute.
- Global overrides, checked every cycle in every state:
  - `alarm_on`=0 or `set_mode`=1 → IDLE.
  - Timers are cleared and `snooze_cnt` is held.
- Priority: `Reset` > (`~alarm_on` | `set_mode`) > `dismiss` > `snooze` > `sec_tick`.
- Counter widths:
  - Ring timer: $clog2(`RING_SECS`) bits.
  - Snooze timer: $clog2(`SNOOZE_SECS`+1) bits.
  - No counter may wrap. Compare-then-transition.

## Timing
- `ring`, `snoozing`, `snooze_cnt`, `amin` and `ahrs` are all registered outputs.
- `match` rises in cycle N with `alarm_on`=1 and `set_mode`=0 → `ring`=1 from cycle N+1.
- A `dismiss` or `snooze` pulse in cycle N → `ring`=0 from N+1.
- A `min_inc` in cycle N → new `amin` visible from N+1.
- Ring duration: `RING_SECS` `sec_tick` pulses after entry. The partial second at entry counts as zero ticks.
- Snooze duration: exactly `SNOOZE_SECS` ticks from the snooze press until `ring` re-asserts.
- `Reset` asserted mid-ring → `ring`=0 asynchronously, without waiting for a clock edge.
- A `match` that is already high when `Reset` deasserts does not ring.

## Test plan
- Setting:
  - Reset, then `set_mode`=1.
  - 61 `min_inc` pulses → `amin`=1.
  - 25 `hrs_inc` pulses → `ahrs`=1.
  - Pulses with `set_mode`=0 leave the values unchanged.
- Ring timeout:
  - `alarm_on`=1, raise `match` → `ring`=1 on the next cycle.
  - After 60 `sec_tick` pulses → `ring`=0.
  - Keep `match` high for 10 more ticks → `ring` stays 0.
  - Drop and re-raise `match` → rings again.
- Snooze:
  - While ringing, pulse `snooze` → `snoozing`=1, `ring`=0, `snooze_cnt`=1.
  - After 540 ticks → `ring`=1.
  - Repeat snooze until `snooze_cnt`=3.
  - A 4th `snooze` is ignored and `ring` stays 1.
- Dismiss and simultaneous events:
  - `dismiss` and `snooze` in the same cycle while ringing → DONE, `ring`=0, `snooze_cnt` unchanged.
  - `dismiss` during SNOOZE → `snoozing`=0.
- Overrides:
  - `alarm_on`→0 while ringing → `ring`=0 next cycle, state IDLE.
  - `set_mode`=1 while snoozing → `snoozing`=0.
  - `match` rising while `set_mode`=1 → no ring.
- Reset:
  - Assert `Reset` mid-ring, between clock edges → `ring`=0 immediately.
  - Release `Reset` with `match`=1 → no ring until `match` falls and rises again.
